// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and frame constants for the program loader
package loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Frame layout: two length bytes, then little-endian 32-bit words
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    // Running frame checksum is a plain XOR of every byte before CHK
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - byte-to-word assembler, little-endian byte lanes
module loader_word_asm
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic [31:0]       word,
    output logic              word_valid,
    output logic [LANE_W-1:0] lane
);

    logic [23:0] low_bytes;

    // Capture the lower three lanes; the top lane is taken straight from the input
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            low_bytes <= '0;
            lane      <= '0;
        end else if (byte_valid) begin
            case (lane)
                2'd0:    low_bytes[7:0]   <= byte_data;
                2'd1:    low_bytes[15:8]  <= byte_data;
                2'd2:    low_bytes[23:16] <= byte_data;
                default: low_bytes        <= low_bytes;
            endcase
            lane <= lane + 2'd1;
        end
    end

    // The word is complete in the same cycle its last byte arrives
    always_comb begin
        word_valid = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));
        word       = {byte_data, low_bytes};
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader writing instruction memory
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       len_full;
    logic              len_over;
    logic [7:0]        checksum;
    logic              accept;
    logic              restart;
    logic              idle_like;
    logic [31:0]       asm_word;
    logic              asm_word_valid;
    logic [LANE_W-1:0] asm_lane;
    logic              last_written;

    // Handshake, restart qualification and length decode
    always_comb begin
        idle_like    = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
        restart      = start && idle_like;
        in_ready     = ((state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_CHECK) ||
                        ((state == ST_DATA) && !mem_we));
        accept       = in_valid && in_ready;
        len_full     = {in_data, len_lo};
        len_over     = {1'b0, len_full} > 17'(DEPTH);
        last_written = mem_we && (16'(words_written) == len) && (asm_lane == '0);
    end

    loader_word_asm u_word_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .lane       (asm_lane)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_over)             state_nxt = ST_ERROR;
                    else if (len_full == '0) state_nxt = ST_CHECK;
                    else                     state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_written) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept) state_nxt = (in_data == checksum) ? ST_DONE : ST_ERROR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Length capture, checksum, memory write port and status outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            len_lo        <= '0;
            len           <= '0;
            checksum      <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we <= asm_word_valid;
            if (asm_word_valid) begin
                mem_wdata     <= asm_word;
                mem_addr      <= words_written[ADDR_WIDTH-1:0];
                words_written <= words_written + 1'b1;
            end
            if (restart) begin
                checksum      <= '0;
                words_written <= '0;
                cpu_hold      <= 1'b1;
                load_done     <= 1'b0;
                load_error    <= 1'b0;
            end
            if (accept && (state != ST_CHECK)) begin
                checksum <= chk_update(checksum, in_data);
            end
            if (accept && (state == ST_LEN_LO)) begin
                len_lo <= in_data;
            end
            if (accept && (state == ST_LEN_HI)) begin
                len <= len_full;
                if (len_over) load_error <= 1'b1;
            end
            if (accept && (state == ST_CHECK)) begin
                if (in_data == checksum) begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end else begin
                    load_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed and randomized bench for prog_loader
module tb_prog_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_written;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] wq[$];

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_written (words_written)
    );

    always #5 clock = ~clock;

    // Record every memory write as {addr, data}
    always @(negedge clock) begin
        if (reset && mem_we) wq.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        check({tag, ".mem_we"}, 64'(mem_we), 64'd0);
        check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, ".cpu_hold"}, 64'(cpu_hold), 64'd1);
        check({tag, ".load_done"}, 64'(load_done), 64'd0);
        check({tag, ".load_error"}, 64'(load_error), 64'd0);
        check({tag, ".words_written"}, 64'(words_written), 64'd0);
    endtask

    // Build a frame from words; corrupt flips bit 0 of CHK
    task automatic build_frame(input logic [31:0] w[$], input bit corrupt, output logic [7:0] fb[$]);
        logic [7:0] chk;
        int n;
        n = w.size();
        fb.delete();
        fb.push_back(8'(n));
        fb.push_back(8'(n >> 8));
        foreach (w[i]) for (int b = 0; b < 4; b++) fb.push_back(8'(w[i] >> (8 * b)));
        chk = 8'h00;
        foreach (fb[i]) chk = chk ^ fb[i];
        fb.push_back(corrupt ? (chk ^ 8'h01) : chk);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Drive count bytes of fb; mode 0 steady, 1 alternate valid, 2 random gaps.
    // in_ready is expected high throughout, except the cycle after each word's last byte.
    task automatic send_bytes(input logic [7:0] fb[$], input int count, input int mode);
        int  idx = 0;
        int  guard = 0;
        bit  bubble = 1'b0;
        bit  acc;
        bit  drive;
        while (idx < count && guard < 4000) begin
            case (mode)
                1:       drive = (guard % 2 == 0);
                2:       drive = ($urandom_range(0, 2) != 0);
                default: drive = 1'b1;
            endcase
            in_valid = drive;
            in_data  = drive ? fb[idx] : 8'h00;
            #1;
            check("in_ready", 64'(in_ready), 64'(!bubble));
            acc = in_valid && in_ready;
            @(posedge clock);
            bubble = 1'b0;
            if (acc) begin
                if (idx >= 2 && idx < fb.size() - 1 && ((idx - 2) % 4 == 3)) bubble = 1'b1;
                idx++;
            end
            @(negedge clock);
            guard++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (idx < count) check("send_timeout", 64'(idx), 64'(count));
    endtask

    // Reference: derive expected writes and status from the frame bytes alone
    task automatic run_frame(input string tag, input logic [7:0] fb[$], input int mode);
        int         len;
        bit         over;
        logic [7:0] chk;
        bit         good;
        int         nsend;
        len  = {fb[1], fb[0]};
        over = (len > DEPTH);
        wq.delete();
        pulse_start();
        nsend = over ? 2 : fb.size();
        send_bytes(fb, nsend, mode);
        repeat (2) @(negedge clock);
        if (over) begin
            good = 1'b0;
            len  = 0;
        end else begin
            chk = 8'h00;
            for (int i = 0; i < fb.size() - 1; i++) chk = chk ^ fb[i];
            good = (chk == fb[fb.size() - 1]);
        end
        check({tag, ".load_done"}, 64'(load_done), 64'(good));
        check({tag, ".load_error"}, 64'(load_error), 64'(!good));
        check({tag, ".cpu_hold"}, 64'(cpu_hold), 64'(!good));
        check({tag, ".words_written"}, 64'(words_written), 64'(len));
        check({tag, ".n_writes"}, 64'(wq.size()), 64'(len));
        for (int i = 0; i < len && i < wq.size(); i++) begin
            logic [31:0] wexp;
            for (int b = 0; b < 4; b++) wexp[8 * b +: 8] = fb[2 + 4 * i + b];
            check({tag, ".write"}, 64'(wq[i]), 64'({8'(i), wexp}));
        end
    endtask

    initial begin
        logic [31:0] w[$];
        logic [7:0]  fb[$];

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);

        // Basic two-word program, then the same frame with alternating valid
        w = '{32'h00500093, 32'h00A00113};
        build_frame(w, 1'b0, fb);
        run_frame("basic", fb, 0);
        check("basic.addr0", 64'(wq.size() > 0 ? wq[0] : 40'h0), 64'({8'h00, 32'h00500093}));
        check("basic.addr1", 64'(wq.size() > 1 ? wq[1] : 40'h0), 64'({8'h01, 32'h00A00113}));
        run_frame("toggle", fb, 1);

        // Bad checksum on a single word
        w = '{32'hDEADBEEF};
        build_frame(w, 1'b1, fb);
        run_frame("badchk", fb, 0);

        // Length one beyond memory depth
        fb = '{8'h01, 8'h01};
        run_frame("overflow", fb, 0);
        check("overflow.err", 64'(load_error), 64'd1);

        // Empty program
        w.delete();
        build_frame(w, 1'b0, fb);
        run_frame("empty", fb, 0);

        // Reset in the middle of a three-word load
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        build_frame(w, 1'b0, fb);
        pulse_start();
        send_bytes(fb, 8, 0);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("midreset");
        @(negedge clock);
        reset = 1'b1;
        w = '{32'hCAFEF00D};
        build_frame(w, 1'b0, fb);
        run_frame("after_reset", fb, 0);

        // Randomized frames with random gaps and occasional checksum corruption
        for (int t = 0; t < 6; t++) begin
            w.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) w.push_back($urandom);
            build_frame(w, ($urandom_range(0, 3) == 0), fb);
            run_frame("random", fb, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the write side of the CPU's instruction/register path.
- Receives a framed program over a valid/ready byte interface, assembles 32-bit little-endian instruction words and writes them into the instruction memory through a single write port.
- Holds the CPU in reset until a load completes with a correct checksum.
- Sits between the testbench/host byte source and the instruction memory; drives the cpu reset input.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load (honoured in IDLE, DONE, ERROR only).
- in_valid  input  1  byte source has data.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  active-high reset to the cpu.
- load_done  output  1  level; load finished with good checksum.
- load_error  output  1  level; length overflow or checksum mismatch.
- words_written  output  ADDR_WIDTH+1  count of words written in the current load.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word LSB first), then one CHK byte. CHK = XOR of every preceding frame byte, including both length bytes.
- A byte transfers when in_valid && in_ready on a rising clock edge.
- Reset (reset==0 at an edge), including mid-load:
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, words_written=0.
  - Running checksum and byte index cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR, on start:
  - Go to LEN_LO; cpu_hold=1; load_done=0; load_error=0.
  - words_written=0; checksum=0.
- in_ready=1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in every other state, and in DATA during the cycle mem_we=1 (one-cycle bubble per word).
- LEN_LO: accepted byte gives len[7:0]; go to LEN_HI.
- LEN_HI: accepted byte gives len[15:8].
  - len > DEPTH: go to ERROR; no memory write.
  - len == 0: go to CHECK.
  - Otherwise go to DATA.
- DATA: bytes shift into a 32-bit assembly register at byte lanes 0..3. On acceptance of the 4th byte of a word, in the next cycle:
  - mem_we=1 for exactly one cycle.
  - mem_wdata = assembled word.
  - mem_addr = word index (0..len-1, ADDR_WIDTH bits).
  - words_written increments in that same cycle.
  - After the write of word len-1, go to CHECK.
- CHECK: accepted byte is compared against the running checksum.
  - Equal: go to DONE; load_done=1; cpu_hold=0 from the next cycle.
  - Not equal: go to ERROR; load_error=1; cpu_hold stays 1.
- Checksum updates on every accepted byte except CHK itself.
- start outside IDLE/DONE/ERROR is ignored.
- in_valid with in_ready=0 is held off; no byte is lost or duplicated.
- Address never wraps: len ≤ DEPTH is enforced before DATA, so the last address is DEPTH-1.
- Words already written before an error stay in memory; load_error is the only indication.

Decomposition:
- Shared package (loader_pkg): state encoding constants, frame field constants (LEN bytes=2, BYTES_PER_WORD=4).
- One sub-module, loader_word_asm: byte-to-word assembler. It takes byte/valid in and produces a word plus a word_valid pulse and byte lane index; it is cleared on reset or start.
- The FSM, checksum and counters stay in prog_loader.

Test Plan:
- N=2, words 0x00500093, 0x00A00113, correct CHK:
  - mem_we pulses twice: addr0 = 0x00500093, addr1 = 0x00A00113.
  - load_done=1, cpu_hold falls, words_written=2.
- Same frame, in_valid toggling every other cycle: identical memory writes.
  - in_ready=0 exactly in the cycle after each 4th byte; no dropped bytes.
- N=1, CHK deliberately XOR 0x01:
  - Word is written to addr0.
  - load_error=1, load_done=0, cpu_hold stays 1.
- LEN = DEPTH+1 (0x0101 with ADDR_WIDTH=8):
  - ERROR right after LEN_HI; mem_we never asserts.
- N=0, CHK=0x00: load_done=1 with words_written=0.
- Assert reset=0 after 6 data bytes of an N=3 load, then restart with a fresh N=1 frame:
  - All outputs at reset values during reset.
  - New word lands at addr0; load_done=1.
